sdram_port_arbiter: RTL

Shares one SDRAM channel between two independent requesters (cartridge slot engine and ioctl loader/mapper path) inside the MSX1 core. Each requester issues single-byte read or write pulses. The arbiter latches them, grants one at a time, and drives exactly one downstream transaction per grant. It returns read data and a one-cycle completion pulse to the granted requester. It sits between `slots` and one element of the `sdram_*[2]` port arrays.

---
 rtl/sdram_port_arbiter_if.sv | 51 +++++
 rtl/sdram_port_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if
//
// Purpose: bundles the two requester ports and the downstream SDRAM port of
// sdram_port_arbiter into one interface.
//
// Signals:
//   r0_*/r1_*      requester side: rd/we pulses, addr, din in; dout, ready out
//   overrun        sticky per-requester "request dropped" flags
//   sdram_*        downstream side: rd/we pulse, addr, din out; dout, ready in
//
// Modports:
//   slave   arbiter view (requests and SDRAM responses in, everything else out)
//   master  environment view (drives requests and SDRAM responses)
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 8
);
  logic              r0_rd;
  logic              r1_rd;
  logic              r0_we;
  logic              r1_we;
  logic [ADDR_W-1:0] r0_addr;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r0_din;
  logic [DATA_W-1:0] r1_din;
  logic [DATA_W-1:0] r0_dout;
  logic [DATA_W-1:0] r1_dout;
  logic              r0_ready;
  logic              r1_ready;
  logic [1:0]        overrun;
  logic              sdram_rd;
  logic              sdram_we;
  logic [ADDR_W-1:0] sdram_addr;
  logic [DATA_W-1:0] sdram_din;
  logic [DATA_W-1:0] sdram_dout;
  logic              sdram_ready;

  modport slave (
    input  r0_rd, r1_rd, r0_we, r1_we, r0_addr, r1_addr, r0_din, r1_din,
    input  sdram_dout, sdram_ready,
    output r0_dout, r1_dout, r0_ready, r1_ready, overrun,
    output sdram_rd, sdram_we, sdram_addr, sdram_din
  );

  modport master (
    output r0_rd, r1_rd, r0_we, r1_we, r0_addr, r1_addr, r0_din, r1_din,
    output sdram_dout, sdram_ready,
    input  r0_dout, r1_dout, r0_ready, r1_ready, overrun,
    input  sdram_rd, sdram_we, sdram_addr, sdram_din
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//
// Purpose: shares one SDRAM channel between two single-byte requesters
// (cartridge slot engine and ioctl loader/mapper). Each request pulse is
// latched into a per-requester pending slot; one slot is granted at a time,
// issues exactly one downstream command, and on downstream completion the
// granted requester receives its read data and a one-cycle ready pulse.
//
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset
//   bus    sdram_port_arbiter_if.slave (requester and SDRAM signals)
//
// Configuration:
//   SDRAM_ARB_RR_EN  defined   -> round-robin on ties (last-grant register)
//                    undefined -> fixed priority, requester 0 wins ties
//
// All outputs are registered.
module sdram_port_arbiter #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 8
) (
  input logic                 clk,
  input logic                 reset,
  sdram_port_arbiter_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [1:0]        valid_q, valid_d;
  logic [1:0]        isWrite_q, isWrite_d;
  logic [ADDR_W-1:0] pendAddr_q [2];
  logic [ADDR_W-1:0] pendAddr_d [2];
  logic [DATA_W-1:0] pendDin_q [2];
  logic [DATA_W-1:0] pendDin_d [2];
  logic              grant_q, grant_d;
  logic              sdramRd_q, sdramRd_d;
  logic              sdramWe_q, sdramWe_d;
  logic [ADDR_W-1:0] sdramAddr_q, sdramAddr_d;
  logic [DATA_W-1:0] sdramDin_q, sdramDin_d;
  logic [DATA_W-1:0] dout_q [2];
  logic [DATA_W-1:0] dout_d [2];
  logic [1:0]        ready_q, ready_d;
  logic [1:0]        overrun_q, overrun_d;

  logic [1:0]        reqRd;
  logic [1:0]        reqWe;
  logic [ADDR_W-1:0] reqAddr [2];
  logic [DATA_W-1:0] reqDin [2];
  logic              winner;

  assign reqRd      = {bus.r1_rd, bus.r0_rd};
  assign reqWe      = {bus.r1_we, bus.r0_we};
  assign reqAddr[0] = bus.r0_addr;
  assign reqAddr[1] = bus.r1_addr;
  assign reqDin[0]  = bus.r0_din;
  assign reqDin[1]  = bus.r1_din;

`ifdef SDRAM_ARB_RR_EN
  logic lastGrant_q, lastGrant_d;

  // On a tie the requester that was not granted last wins; otherwise the
  // only valid requester wins.
  always_comb begin
    winner = (valid_q == 2'b11) ? ~lastGrant_q : ~valid_q[0];
  end
`else
  // Requester 0 wins whenever it is valid.
  always_comb begin
    winner = ~valid_q[0];
  end
`endif

  // Next-state logic. The FSM issues a one-cycle command from IDLE and waits
  // for sdram_ready in WAIT. Completion clears the granted slot first, then
  // new request pulses are applied, so a pulse landing on the completion
  // edge reloads the slot instead of being counted as an overrun.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    isWrite_d   = isWrite_q;
    pendAddr_d  = pendAddr_q;
    pendDin_d   = pendDin_q;
    grant_d     = grant_q;
    sdramRd_d   = 1'b0;
    sdramWe_d   = 1'b0;
    sdramAddr_d = sdramAddr_q;
    sdramDin_d  = sdramDin_q;
    dout_d      = dout_q;
    ready_d     = 2'b00;
    overrun_d   = overrun_q;
`ifdef SDRAM_ARB_RR_EN
    lastGrant_d = lastGrant_q;
`endif

    case (state_q)
      IDLE: begin
        if (|valid_q) begin
          grant_d     = winner;
          sdramAddr_d = pendAddr_q[winner];
          sdramDin_d  = pendDin_q[winner];
          sdramWe_d   = isWrite_q[winner];
          sdramRd_d   = ~isWrite_q[winner];
          state_d     = WAIT;
`ifdef SDRAM_ARB_RR_EN
          lastGrant_d = winner;
`endif
        end
      end
      WAIT: begin
        if (bus.sdram_ready) begin
          if (!isWrite_q[grant_q]) begin
            dout_d[grant_q] = bus.sdram_dout;
          end
          ready_d[grant_q] = 1'b1;
          valid_d[grant_q] = 1'b0;
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    for (int i = 0; i < 2; i++) begin
      if (reqRd[i] || reqWe[i]) begin
        if (valid_d[i]) begin
          overrun_d[i] = 1'b1;
        end else begin
          valid_d[i]    = 1'b1;
          isWrite_d[i]  = reqWe[i];
          pendAddr_d[i] = reqAddr[i];
          pendDin_d[i]  = reqDin[i];
        end
      end
    end
  end

  // State registers with synchronous reset. Reset abandons any transaction
  // in flight; its late sdram_ready then arrives in IDLE and is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      valid_q     <= 2'b00;
      isWrite_q   <= 2'b00;
      grant_q     <= 1'b0;
      sdramRd_q   <= 1'b0;
      sdramWe_q   <= 1'b0;
      sdramAddr_q <= '0;
      sdramDin_q  <= '0;
      ready_q     <= 2'b00;
      overrun_q   <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        pendAddr_q[i] <= '0;
        pendDin_q[i]  <= '0;
        dout_q[i]     <= '0;
      end
`ifdef SDRAM_ARB_RR_EN
      lastGrant_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      isWrite_q   <= isWrite_d;
      pendAddr_q  <= pendAddr_d;
      pendDin_q   <= pendDin_d;
      grant_q     <= grant_d;
      sdramRd_q   <= sdramRd_d;
      sdramWe_q   <= sdramWe_d;
      sdramAddr_q <= sdramAddr_d;
      sdramDin_q  <= sdramDin_d;
      dout_q      <= dout_d;
      ready_q     <= ready_d;
      overrun_q   <= overrun_d;
`ifdef SDRAM_ARB_RR_EN
      lastGrant_q <= lastGrant_d;
`endif
    end
  end

  assign bus.r0_dout    = dout_q[0];
  assign bus.r1_dout    = dout_q[1];
  assign bus.r0_ready   = ready_q[0];
  assign bus.r1_ready   = ready_q[1];
  assign bus.overrun    = overrun_q;
  assign bus.sdram_rd   = sdramRd_q;
  assign bus.sdram_we   = sdramWe_q;
  assign bus.sdram_addr = sdramAddr_q;
  assign bus.sdram_din  = sdramDin_q;

endmodule
